// File: rtl/alu_seq_if.sv
// alu_seq_if: handshake bus for the alu_seq execute unit.
// The request side carries op/operands, the response side carries result/zero.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             inValid;
  logic             inReady;
  logic [2:0]       aluControl;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic             outValid;
  logic             outReady;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport slave (
    input  inValid, aluControl, srcA, srcB, outReady,
    output inReady, outValid, result, zero
  );

  modport master (
    output inValid, aluControl, srcA, srcB, outReady,
    input  inReady, outValid, result, zero
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered, handshaked execute unit driven by the 3-bit aluControl.
// Single-cycle ops: add, sub, and, or, xor, slt.
// Optional macro ALU_SHIFT_EN builds the iterative one-bit-per-cycle shifter
// (sll/srl). Without it, ops 110/111 return result 0 with zero set.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_seq_if.slave bus
);

  logic             w_out_free;
  logic             w_fire_in;
  logic             w_inReady;
  logic             w_load;
  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_alu;
  logic             r_outValid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;

  function automatic logic [WIDTH-1:0] alu_op(input logic [2:0] ctl,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    sa = a;
    sb = b;
    case (ctl)
      3'b000:  alu_op = a + b;
      3'b001:  alu_op = a - b;
      3'b010:  alu_op = a & b;
      3'b011:  alu_op = a | b;
      3'b100:  alu_op = a ^ b;
      3'b101:  alu_op = (sa < sb) ? WIDTH'(1) : '0;
`ifdef ALU_SHIFT_EN
      // Only reached for a shift by zero, which passes A through unchanged.
      default: alu_op = a;
`else
      default: alu_op = '0;
`endif
    endcase
  endfunction

  assign w_out_free = !r_outValid || bus.outReady;
  assign w_fire_in  = bus.inValid && w_inReady;
  assign w_alu      = alu_op(bus.aluControl, bus.srcA, bus.srcB);

`ifdef ALU_SHIFT_EN
  localparam int SHW = $clog2(WIDTH);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_work;
  logic [SHW-1:0]   r_cnt;
  logic             r_dir;
  logic             w_start;
  logic             w_step;
  logic             w_is_shift;
  logic [SHW-1:0]   w_amt;
  logic [WIDTH-1:0] w_shifted;

  assign w_is_shift = (bus.aluControl[2:1] == 2'b11);
  assign w_amt      = bus.srcB[SHW-1:0];
  assign w_shifted  = r_dir ? (r_work >> 1) : (r_work << 1);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state, handshake and load decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_inReady   = 1'b0;
    w_load      = 1'b0;
    w_load_val  = '0;
    w_start     = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_inReady = rst_n && w_out_free;
        if (bus.inValid && w_inReady) begin
          if (w_is_shift && (w_amt != '0)) begin
            w_start     = 1'b1;
            w_state_nxt = S_SHIFT;
          end else begin
            w_load     = 1'b1;
            w_load_val = w_alu;
          end
        end
      end
      S_SHIFT: begin
        if (r_cnt == SHW'(1)) begin
          // Last step waits for the output register to be free.
          if (w_out_free) begin
            w_step      = 1'b1;
            w_load      = 1'b1;
            w_load_val  = w_shifted;
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_step = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Shift work register, remaining-step counter and direction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_work <= '0;
      r_cnt  <= '0;
      r_dir  <= 1'b0;
    end else if (w_start) begin
      r_work <= bus.srcA;
      r_cnt  <= w_amt;
      r_dir  <= bus.aluControl[0];
    end else if (w_step) begin
      r_work <= w_shifted;
      r_cnt  <= r_cnt - SHW'(1);
    end
  end
`else
  // Every op completes in one cycle; readiness depends only on the output.
  always_comb begin
    w_inReady  = rst_n && w_out_free;
    w_load     = w_fire_in;
    w_load_val = w_alu;
  end
`endif

  // Output register: load on completion, clear valid on drain, else hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_outValid <= 1'b0;
      r_result   <= '0;
      r_zero     <= 1'b0;
    end else if (w_load) begin
      r_outValid <= 1'b1;
      r_result   <= w_load_val;
      r_zero     <= (w_load_val == '0);
    end else if (bus.outReady) begin
      r_outValid <= 1'b0;
    end
  end

  assign bus.inReady  = w_inReady;
  assign bus.outValid = r_outValid;
  assign bus.result   = r_result;
  assign bus.zero     = r_zero;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: table-driven directed bench for alu_seq (WIDTH=32), with
// hand-written sequences for reset, backpressure and (if built) shifting.
module tb_alu_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  alu_seq_if #(.WIDTH(32)) bus ();

  alu_seq #(.WIDTH(32)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Present one op, wait (bounded) for acceptance, complete the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    bus.inValid    = 1'b1;
    bus.aluControl = op;
    bus.srcA       = a;
    bus.srcB       = b;
    #1;
    while (!bus.inReady && n < 20) begin
      tick();
      n++;
    end
    check("accept_ready", 32'(bus.inReady), 32'd1);
    tick();
    bus.inValid    = 1'b0;
    bus.aluControl = 3'b111;
    bus.srcA       = 32'hDEAD_BEEF;
    bus.srcB       = 32'hFFFF_FFFF;
  endtask

`ifdef ALU_SHIFT_EN
  // Shift by n>0: busy and no result for n cycles after accept, then result.
  task automatic run_shift(input string name, input logic [2:0] op, input logic [31:0] a,
                           input int n, input logic [31:0] exp);
    issue(op, a, 32'(n));
    for (int i = 0; i < n; i++) begin
      check({name, "_busy_valid"}, 32'(bus.outValid), 32'd0);
      check({name, "_busy_ready"}, 32'(bus.inReady), 32'd0);
      tick();
    end
    check({name, "_valid"}, 32'(bus.outValid), 32'd1);
    check({name, "_result"}, bus.result, exp);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{3'b000, 32'd5,          32'd7,          32'd12,         1'b0};
    vecs[1] = '{3'b001, 32'd7,          32'd7,          32'd0,          1'b1};
    vecs[2] = '{3'b001, 32'd0,          32'd1,          32'hFFFF_FFFF,  1'b0};
    vecs[3] = '{3'b010, 32'h0000_00F0,  32'h0000_003C,  32'h0000_0030,  1'b0};
    vecs[4] = '{3'b011, 32'h0000_00F0,  32'h0000_003C,  32'h0000_00FC,  1'b0};
    vecs[5] = '{3'b100, 32'h0000_00F0,  32'h0000_003C,  32'h0000_00CC,  1'b0};
    vecs[6] = '{3'b101, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0};
    vecs[7] = '{3'b101, 32'd1,          32'hFFFF_FFFF,  32'd0,          1'b1};
    vecs[8] = '{3'b101, 32'h8000_0000,  32'h7FFF_FFFF,  32'd1,          1'b0};
    vecs[9] = '{3'b000, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b1};

    bus.inValid    = 1'b1;
    bus.outReady   = 1'b0;
    bus.aluControl = 3'b000;
    bus.srcA       = 32'd1;
    bus.srcB       = 32'd1;

    // Reset held two cycles with a request pending.
    tick();
    tick();
    check("rst_outValid", 32'(bus.outValid), 32'd0);
    check("rst_result",   bus.result,        32'd0);
    check("rst_zero",     32'(bus.zero),     32'd0);
    check("rst_inReady",  32'(bus.inReady),  32'd0);
    bus.inValid = 1'b0;
    rst_n = 1'b1;
    #1;
    check("rel_inReady", 32'(bus.inReady), 32'd1);

    // Back-to-back single-cycle ops with the consumer always ready.
    bus.outReady = 1'b1;
    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("vec%0d_valid", i),  32'(bus.outValid), 32'd1);
      check($sformatf("vec%0d_result", i), bus.result,        vecs[i].res);
      check($sformatf("vec%0d_zero", i),   32'(bus.zero),     32'(vecs[i].z));
    end
    tick();
    check("drain_valid", 32'(bus.outValid), 32'd0);

    // Backpressure: result held, no accept, then drain and accept together.
    bus.outReady = 1'b0;
    issue(3'b000, 32'd2, 32'd3);
    check("bp_first_valid",  32'(bus.outValid), 32'd1);
    check("bp_first_result", bus.result,        32'd5);
    bus.inValid    = 1'b1;
    bus.aluControl = 3'b000;
    bus.srcA       = 32'd4;
    bus.srcB       = 32'd4;
    #1;
    check("bp_inReady_low", 32'(bus.inReady), 32'd0);
    tick();
    check("bp_hold_result", bus.result,        32'd5);
    check("bp_hold_valid",  32'(bus.outValid), 32'd1);
    bus.outReady = 1'b1;
    #1;
    check("bp_inReady_high", 32'(bus.inReady), 32'd1);
    tick();
    bus.inValid = 1'b0;
    check("bp_next_valid",  32'(bus.outValid), 32'd1);
    check("bp_next_result", bus.result,        32'd8);
    tick();
    check("bp_drained", 32'(bus.outValid), 32'd0);

`ifdef ALU_SHIFT_EN
    run_shift("sll4", 3'b110, 32'h1, 4, 32'h10);
    check("sll4_zero", 32'(bus.zero), 32'd0);
    run_shift("srl31", 3'b111, 32'h8000_0000, 31, 32'h1);
    issue(3'b110, 32'h1, 32'd0);
    check("sll0_valid",  32'(bus.outValid), 32'd1);
    check("sll0_result", bus.result,        32'h1);
    tick();

    // Reset two cycles into a long shift.
    issue(3'b110, 32'h1, 32'd10);
    tick();
    rst_n = 1'b0;
    tick();
    check("mid_rst_valid", 32'(bus.outValid), 32'd0);
    check("mid_rst_ready", 32'(bus.inReady),  32'd0);
    rst_n = 1'b1;
    #1;
    check("mid_rel_ready", 32'(bus.inReady), 32'd1);
    for (int i = 0; i < 12; i++) begin
      check("mid_rel_quiet", 32'(bus.outValid), 32'd0);
      tick();
    end
    issue(3'b000, 32'd1, 32'd1);
    check("mid_add_valid",  32'(bus.outValid), 32'd1);
    check("mid_add_result", bus.result,        32'd2);
`else
    issue(3'b110, 32'h1, 32'd4);
    check("noshift_sll_valid",  32'(bus.outValid), 32'd1);
    check("noshift_sll_result", bus.result,        32'd0);
    check("noshift_sll_zero",   32'(bus.zero),     32'd1);
    issue(3'b111, 32'h8000_0000, 32'd31);
    check("noshift_srl_valid",  32'(bus.outValid), 32'd1);
    check("noshift_srl_result", bus.result,        32'd0);
    check("noshift_srl_zero",   32'(bus.zero),     32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Registered, handshaked execute unit that consumes the 3-bit `aluControl` produced by the ALU decoder. It performs the selected operation on two operands and returns the result with a zero flag. Sits between decode and writeback/branch logic in the multicycle datapath. Single-cycle ops complete in one cycle; shift ops run iteratively, one bit per cycle.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; power of two, ≥ 8.

Ports:
- `clk` in 1, rising-edge clock.
- `rst_n` in 1, reset; synchronous, active-low.
- `inValid` in 1, operands and op are valid.
- `inReady` out 1, unit can accept; transfer on `inValid && inReady`.
- `aluControl` in 3, op select (encoding below).
- `srcA` in WIDTH, operand A (shift source).
- `srcB` in WIDTH, operand B (`srcB[log2(WIDTH)-1:0]` is the shift amount).
- `outValid` out 1, `result`/`zero` valid.
- `outReady` in 1, consumer takes result; transfer on `outValid && outReady`.
- `result` out WIDTH, registered result.
- `zero` out 1, registered, `result == 0`.

## Operation
- Encoding:
  - 000 add
  - 001 sub (A−B, wraps mod 2^WIDTH)
  - 010 and
  - 011 or
  - 100 xor
  - 101 slt: signed A<B → 1, else 0, zero-extended
  - 110 sll (only with `ALU_SHIFT_EN`)
  - 111 srl, logical (only with `ALU_SHIFT_EN`)
- FSM states: IDLE, SHIFT.
- IDLE: `inReady = !outValid || outReady`. On accept of a non-shift op, or a shift with amount 0, `result`/`zero` load at that edge and `outValid` sets.
- IDLE → SHIFT: on accept of a shift with amount n>0. Work register loads `srcA`, counter loads n, and a direction bit is stored.
- SHIFT: `inReady = 0`. Each edge shifts the work register by one bit and decrements the counter.
- SHIFT → IDLE: on the step where the counter goes 1→0, the shifted value loads into `result` and `outValid` sets.
  - If `outValid && !outReady` at that step, the FSM stalls: counter holds at 1, work register holds, nothing loads until the output frees.
- Output register: holds while `outValid && !outReady`. Clears `outValid` on handshake unless reloaded in the same edge; a back-to-back accept plus drain is allowed in IDLE.
- `aluControl`, `srcA`, `srcB` are sampled only at accept; later changes are ignored.
- Reset (`rst_n` low at an edge, any state, including mid-shift):
  - state → IDLE
  - `outValid` = 0, `result` = 0, `zero` = 0
  - counter and work register = 0
  - `inReady` is forced to 0 while `rst_n` is low.

## Timing
- Non-shift op or shift by 0: accepted at edge T, `outValid` high after edge T (1-cycle latency).
- Shift by n: `outValid` high after edge T+n (n+1 cycles from accept), plus any output stall cycles.
- Max throughput: 1 op/cycle for non-shift ops while the consumer holds `outReady` high.
- `inReady` is combinational from state, `outValid` and `outReady`; there is no combinational path from `inValid` to `inReady`.
- All other outputs are registered.

## Configuration
- `ALU_SHIFT_EN` defined:
  - SHIFT state, counter and work register are built.
  - 110/111 behave as above.
- `ALU_SHIFT_EN` not defined:
  - no SHIFT state.
  - 110/111 complete in 1 cycle with `result` = 0, `zero` = 1.
  - `inReady` depends only on the output register.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles → `outValid`=0, `result`=0, `zero`=0, `inReady`=0. Release → `inReady`=1.
- Basic ops (WIDTH=32, `outReady`=1):
  - add 5+7 → 12, zero=0
  - sub 7−7 → 0, zero=1
  - sub 0−1 → 0xFFFFFFFF
  - and 0xF0&0x3C → 0x30
  - or → 0xFC
  - slt −1<1 → 1
  - slt 1<−1 → 0
  - each 1 cycle after accept.
- Shift (`ALU_SHIFT_EN`):
  - sll 0x1 by 4 → 0x10, `outValid` 5 cycles after accept, `inReady`=0 meanwhile.
  - srl 0x80000000 by 31 → 0x1.
  - sll by 0 → 0x1 after 1 cycle.
- Backpressure:
  - `outReady`=0 after a result, new `inValid` → `inReady`=0 and `result` held.
  - Raise `outReady` → drain and accept in the same cycle; next result 1 cycle later.
- Reset mid-shift: `rst_n`=0 two cycles into sll by 10 → IDLE, `outValid` stays 0. After release, add 1+1 → 2 with normal latency.
- Without `ALU_SHIFT_EN`: op 110 with A=0x1, B=4 → `result`=0, `zero`=1, `outValid` 1 cycle after accept.
